mem_access_ctrl: RTL and testbench

// Memory-side sequencer between the CPU datapath (MAR/MDR, control unit) and the
// 512x32 edge-strobed RAM. It accepts one read or write request over a valid/ready

---
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/mem_access_ctrl.sv | 64 ++++++
 tb/tb_mem_access_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response bus plus RAM strobe/data bus of the memory sequencer.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_D;
    logic              ram_read;
    logic              ram_write;
    logic [DATA_W-1:0] ram_Q;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, ram_Q,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, ram_address, ram_D, ram_read, ram_write
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, ram_Q,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, ram_address, ram_D, ram_read, ram_write
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one registered, glitch-free RAM read/write per request
// and returns a one-cycle response carrying read data or an out-of-range error.
module mem_access_ctrl #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int STROBE_CYCLES = 1
) (
    input logic              clock,
    input logic              clear_n,
    mem_access_ctrl_if.slave bus
);
    generate
        if (STROBE_CYCLES < 1 || STROBE_CYCLES > 4) begin : g_bad_cfg
            $error("STROBE_CYCLES must be in 1..4");
        end
    endgenerate
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;
    state_t     state, state_nx;
    logic       write_q;
    logic [1:0] cnt;
    logic       accept, range_err;
    assign accept    = bus.req_valid & bus.req_ready;
    assign range_err = |bus.req_addr[31:ADDR_W];
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (range_err ? RESP : SETUP) : IDLE;
            SETUP:   state_nx = STROBE;
            STROBE:  state_nx = (cnt == 2'(STROBE_CYCLES - 1)) ? HOLD : STROBE;
            HOLD:    state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end
    // Every output is registered from the next state so strobes come straight off flops.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state           <= IDLE;
            write_q         <= 1'b0;
            cnt             <= '0;
            bus.req_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.ram_address <= '0;
            bus.ram_D       <= '0;
            bus.ram_read    <= 1'b0;
            bus.ram_write   <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= (state == STROBE) ? cnt + 2'd1 : 2'd0;
            bus.req_ready <= state_nx == IDLE;
            bus.rsp_valid <= state_nx == RESP;
            bus.rsp_err   <= (state == IDLE) && accept && range_err;
            bus.ram_read  <= (state_nx == STROBE) && !write_q;
            bus.ram_write <= (state_nx == STROBE) && write_q;
            if ((state == IDLE) && accept && !range_err) begin
                write_q         <= bus.req_write;
                bus.ram_address <= bus.req_addr[ADDR_W-1:0];
                if (bus.req_write) bus.ram_D <= bus.req_wdata;
            end
            if ((state == HOLD) && !write_q) bus.rsp_rdata <= bus.ram_Q;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against a behavioural edge-strobed RAM.
module tb_mem_access_ctrl;
    logic clock, clear_n;
    int errors, checks;
    int rd_edges, wr_edges, rv_cnt, rd3_cnt;
    logic [31:0] mem [512];
    mem_access_ctrl_if #(.ADDR_W(9), .DATA_W(32)) bus ();
    mem_access_ctrl_if #(.ADDR_W(9), .DATA_W(32)) bus3 ();
    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .STROBE_CYCLES(1)) dut (
        .clock(clock), .clear_n(clear_n), .bus(bus.slave));
    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .STROBE_CYCLES(3)) dut3 (
        .clock(clock), .clear_n(clear_n), .bus(bus3.slave));
    initial clock = 1'b0;
    always #5 clock = ~clock;
    // RAM model acting on strobe rising edges
    initial begin
        rd_edges = 0;
        wr_edges = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[9'h068] = 32'h0000_0055;
        mem[9'h0F0] = 32'h0000_FFFF;
        forever begin
            @(posedge bus.ram_read or posedge bus.ram_write);
            if (bus.ram_write) begin
                mem[bus.ram_address] = bus.ram_D;
                wr_edges++;
            end else begin
                bus.ram_Q = mem[bus.ram_address];
                rd_edges++;
            end
        end
    end
    initial begin
        rd3_cnt = 0;
        forever begin
            @(posedge bus3.ram_read);
            bus3.ram_Q = 32'hA5A5_0000 ^ {23'h0, bus3.ram_address};
            rd3_cnt++;
        end
    end
    initial begin
        rv_cnt = 0;
        forever begin
            @(posedge bus.rsp_valid);
            rv_cnt++;
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int hi_first, output int hi_cnt,
                       output logic [31:0] rdata, output logic err);
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        lat = -1; hi_first = -1; hi_cnt = 0; rdata = '0; err = 1'b0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            if (bus.ram_read | bus.ram_write) begin
                if (hi_first < 0) hi_first = k;
                hi_cnt++;
            end
            if (bus.rsp_valid) begin
                lat = k;
                rdata = bus.rsp_rdata;
                err = bus.rsp_err;
            end else begin
                @(posedge clock); #1;
            end
        end
        if (lat < 0) check("rsp_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        check("rsp_one_cycle", {31'h0, bus.rsp_valid}, 32'd0);
        check("ready_back", {31'h0, bus.req_ready}, 32'd1);
    endtask
    initial begin
        int lat, hf, hc, n, e0, w0;
        logic [31:0] rd, rdat [3];
        logic er, rdy;
        int rtime [3];
        logic [31:0] addrs [3];
        errors = 0;
        checks = 0;
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus3.req_valid = 0; bus3.req_write = 0; bus3.req_addr = 0; bus3.req_wdata = 0;
        clear_n = 1'b1;
        #2 clear_n = 1'b0;
        #1;
        check("rst_ready", {31'h0, bus.req_ready}, 32'd1);
        check("rst_valid", {31'h0, bus.rsp_valid}, 32'd0);
        check("rst_err", {31'h0, bus.rsp_err}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        check("rst_addr", {23'h0, bus.ram_address}, 32'h0);
        check("rst_D", bus.ram_D, 32'h0);
        check("rst_strobes", {30'h0, bus.ram_read, bus.ram_write}, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock) clear_n = 1'b1;
        @(posedge clock); #1;
        // read 0x68
        txn(1'b0, 32'h68, 32'h0, lat, hf, hc, rd, er);
        check("rd68_lat", lat, 32'd3);
        check("rd68_strobe_at", hf, 32'd1);
        check("rd68_strobe_len", hc, 32'd1);
        check("rd68_data", rd, 32'h55);
        check("rd68_err", {31'h0, er}, 32'd0);
        check("rd68_edges", rd_edges, 32'd1);
        // write 0x52 <- 0x2F, then read it back
        txn(1'b1, 32'h52, 32'h2F, lat, hf, hc, rd, er);
        check("wr52_lat", lat, 32'd3);
        check("wr52_strobe_len", hc, 32'd1);
        check("wr52_edges", wr_edges, 32'd1);
        check("wr52_rd_edges", rd_edges, 32'd1);
        check("wr52_D", bus.ram_D, 32'h2F);
        check("wr52_mem", mem[9'h052], 32'h2F);
        check("wr52_rdata_kept", rd, 32'h55);
        txn(1'b0, 32'h52, 32'h0, lat, hf, hc, rd, er);
        check("rd52_data", rd, 32'h2F);
        // out of range
        txn(1'b0, 32'h200, 32'h0, lat, hf, hc, rd, er);
        check("oor_lat", lat, 32'd0);
        check("oor_err", {31'h0, er}, 32'd1);
        check("oor_strobe", hc, 32'd0);
        check("oor_edges", rd_edges + wr_edges, 32'd3);
        check("oor_addr_kept", {23'h0, bus.ram_address}, 32'h52);
        check("oor_rdata_kept", rd, 32'h2F);
        // three back-to-back reads with req_valid held
        addrs[0] = 32'h68; addrs[1] = 32'h52; addrs[2] = 32'hF0;
        e0 = rd_edges;
        n = 0;
        w0 = 0;
        bus.req_write = 1'b0;
        bus.req_addr = addrs[0];
        bus.req_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            rdy = bus.req_ready;
            @(posedge clock); #1;
            if (rdy && bus.req_valid) begin
                w0++;
                if (w0 < 3) bus.req_addr = addrs[w0];
                else bus.req_valid = 1'b0;
            end
            if (bus.rsp_valid && n < 3) begin
                rtime[n] = c;
                rdat[n] = bus.rsp_rdata;
                n++;
            end
        end
        bus.req_valid = 1'b0;
        check("b2b_count", n, 32'd3);
        check("b2b_edges", rd_edges - e0, 32'd3);
        if (n == 3) begin
            check("b2b_gap1", rtime[1] - rtime[0], 32'd5);
            check("b2b_gap2", rtime[2] - rtime[1], 32'd5);
            check("b2b_d0", rdat[0], 32'h55);
            check("b2b_d1", rdat[1], 32'h2F);
            check("b2b_d2", rdat[2], 32'hFFFF);
        end
        // reset during the strobe of a write
        e0 = rv_cnt;
        bus.req_write = 1'b1;
        bus.req_addr = 32'h10;
        bus.req_wdata = 32'hAB;
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(posedge clock); #1;
        check("mid_strobe_high", {31'h0, bus.ram_write}, 32'd1);
        #2 clear_n = 1'b0;
        #1;
        check("mid_strobe_drop", {31'h0, bus.ram_write}, 32'd0);
        check("mid_ready", {31'h0, bus.req_ready}, 32'd1);
        check("mid_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clock) clear_n = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("mid_no_rsp", rv_cnt - e0, 32'd0);
        check("mid_wr_done", mem[9'h010], 32'hAB);
        // STROBE_CYCLES=3 read
        bus3.req_write = 1'b0;
        bus3.req_addr = 32'h33;
        bus3.req_valid = 1'b1;
        @(posedge clock); #1;
        bus3.req_valid = 1'b0;
        lat = -1; hc = 0; rd = '0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            if (bus3.ram_read) hc++;
            if (bus3.rsp_valid) begin
                lat = k;
                rd = bus3.rsp_rdata;
            end else begin
                @(posedge clock); #1;
            end
        end
        if (lat < 0) check("s3_timeout", 32'd0, 32'd1);
        check("s3_lat", lat, 32'd5);
        check("s3_strobe_len", hc, 32'd3);
        check("s3_edges", rd3_cnt, 32'd1);
        check("s3_data", rd, 32'hA5A5_0033);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
